fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of write requesters (2..8).
REQ-002 Parameter MAXBURST, 8, maximum words per grant (1..16).
REQ-003 Parameter DATASIZE, from shared package definitions, FIFO word width.
REQ-004 Clock and reset SHALL be: wclk input 1 clock; wrst_n input 1 reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester word valid.
REQ-006 req_data  input  NREQ*DATASIZE  per-requester word; requester i occupies bits [i*DATASIZE +: DATASIZE].
REQ-007 req_last  input  NREQ  marks final word of requester's packet.
REQ-008 req_ready  output  NREQ  per-requester word accepted this cycle.
REQ-009 winc  output  1  FIFO write strobe.
REQ-010 wdata  output  DATASIZE  FIFO write data.
REQ-011 wfull  input  1  FIFO full flag, wclk domain.
REQ-012 busy  output  1  grant active.
REQ-013 gnt_id  output  $clog2(NREQ)  index of granted requester, valid when busy=1.

Function
REQ-014 FSM SHALL have two states: ARB and BURST.
REQ-015 ARB: if any req_valid=1, select requester by round-robin starting at rr_ptr, register gnt_id, clear beat counter, go to BURST next cycle; else stay in ARB.
REQ-016 ARB: winc=0, req_ready=0 (one-cycle arbitration bubble per grant).
REQ-017 BURST: winc = req_valid[gnt_id] & ~wfull; req_ready[gnt_id] = winc; every other req_ready bit = 0; wdata = req_data slice gnt_id, combinational.
REQ-018 Word accepted only when winc=1; beat counter increments by 1 on each accepted word.
REQ-019 Burst ends on the accepted word with req_last[gnt_id]=1, or on the accepted word that brings beat counter to MAXBURST; next state ARB, rr_ptr = (gnt_id+1) mod NREQ.
REQ-020 wfull=1 in BURST: winc=0, no state, counter or pointer change; grant held until wfull=0.
REQ-021 Granted requester deasserting req_valid mid-burst: grant held, no timeout, no re-arbitration.
REQ-022 Simultaneous last and MAXBURST on one word: single burst end, same transition as REQ-019.
REQ-023 Requests arriving in BURST SHALL be considered only at the next ARB cycle.
REQ-024 busy = (state==BURST).

Reset
REQ-025 wrst_n low SHALL immediately force state=ARB, rr_ptr=0, gnt_id=0, beat counter=0, winc=0, req_ready=0, busy=0, including mid-burst.
REQ-026 First grant after reset SHALL begin search at requester 0.

Configuration
REQ-027 Macro FIFO_WR_ARB_STATS_EN defined: add output stat_words (NREQ*16), one saturating 16-bit count of accepted words per requester, and output stat_stall (16), saturating count of BURST cycles with wfull=1; all reset to 0.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package definitions SHALL hold DATASIZE, ADDRSIZE and the arbiter state enum typedef (ARB, BURST).
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, start pointer; outputs: found flag, index), purely combinational.
REQ-031 fifo_wr_arbiter winc/wdata/wfull SHALL connect directly to the FIFO write port, no extra pipeline stage.

Verification
REQ-032 NREQ=4, req 1 only, 3-word packet, last on word 3 -> gnt_id=1 one cycle after request, winc high 3 consecutive cycles, then ARB, rr_ptr=2.
REQ-033 Reqs 0,2,3 all valid with 1-word packets from reset -> grant order 0,2,3, each separated by one ARB cycle.
REQ-034 Req 0 streams 20 words, no last, MAXBURST=8 -> bursts of 8,8,4; req 1 valid concurrently is granted between req 0's bursts.
REQ-035 wfull=1 for 5 cycles mid-burst -> winc=0 and req_ready=0 for exactly those cycles, no words lost or duplicated, FIFO contents in order.
REQ-036 wrst_n asserted mid-burst after 2 words -> winc, busy drop same cycle; after release, request from 3 and 0 -> req 0 granted first.
REQ-037 With FIFO_WR_ARB_STATS_EN, REQ-034 stimulus -> stat_words[0]=20, stat_stall=0; 70000 words from req 2 -> stat_words[2]=65535.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: word/address widths and FSM state type.
package fifo_wr_arbiter_pkg;

  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             sum;

  always_comb begin
    found = 1'b0;
    off   = 0;
    dbl   = {req, req} >> start;
    rot   = dbl[N-1:0];
    // Walk downwards so the closest requester to start wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = int'(start) + off;
    if (sum >= N) begin
      sum = sum - N;
    end
    idx = IW'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter of NREQ packet writers onto one FIFO write port, bursts capped at MAXBURST.
// Optional per-requester word and full-stall counters under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8,
  parameter int DATASIZE = fifo_wr_arbiter_pkg::DATASIZE
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  input  logic                     wfull,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  gnt_id
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       stat_words,
  output logic [15:0]              stat_stall
`endif
);

  import fifo_wr_arbiter_pkg::*;

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          sel_vld;
  logic          sel_last;

  rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
    .req   (req_valid),
    .start (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= ARB;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      ARB: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // A stalled or idle beat leaves everything untouched; the grant is held.
        if (winc) begin
          if (sel_last || (beat_q == BW'(MAXBURST - 1))) begin
            state_d  = ARB;
            beat_d   = '0;
            rr_ptr_d = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    wdata    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == IW'(i)) begin
        sel_vld  = req_valid[i];
        sel_last = req_last[i];
        wdata    = req_data[i*DATASIZE +: DATASIZE];
      end
    end
    busy      = (state_q == BURST);
    winc      = busy & sel_vld & ~wfull;
    req_ready = winc ? (NREQ'(1) << gnt_q) : '0;
    gnt_id    = gnt_q;
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_words_q, stat_words_d;
  logic [15:0]        stat_stall_q, stat_stall_d;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i] && (stat_words_q[i*16 +: 16] != 16'hFFFF)) begin
        stat_words_d[i*16 +: 16] = stat_words_q[i*16 +: 16] + 16'd1;
      end
    end
    if (busy && wfull && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, corner-case sequences, random traffic vs a rule model.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NREQ     = 4;
  localparam int MAXBURST = 8;
  localparam int DW       = DATASIZE;

  logic                 wclk;
  logic                 wrst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 winc;
  logic [DW-1:0]        wdata;
  logic                 wfull;
  logic                 busy;
  logic [1:0]           gnt_id;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0]   stat_words;
  logic [15:0]          stat_stall;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .MAXBURST(MAXBURST), .DATASIZE(DW)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .busy      (busy),
    .gnt_id    (gnt_id)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_stall(stat_stall)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       full;
    logic       e_busy;
    int         e_gnt;
    logic       e_winc;
    logic [3:0] e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                     input logic b, input int g, input logic w, input logic [3:0] rd);
    vec_t x;
    x.rst_n = r; x.vld = v; x.lst = l; x.full = f;
    x.e_busy = b; x.e_gnt = g; x.e_winc = w; x.e_rdy = rd;
    tbl.push_back(x);
  endtask

  // ---------------- sources, model, scoreboard ----------------
  int words_left[NREQ];
  int pkt_len[NREQ];   // >0 fixed packet length, 0 never last, <0 random 1..12
  int pkt_left[NREQ];
  int seq[NREQ];
  int fifo_seq[NREQ];
  int vld_pct   = 100;
  int wfull_pct = 0;
  logic [NREQ-1:0] acc_vec;
  int owner_log[$];
  logic s_busy, s_winc;
  logic [NREQ-1:0] s_ready;

  int m_busy, m_owner, m_cnt, m_ptr;

  function automatic int reload(input int plen);
    if (plen > 0) return plen;
    if (plen < 0) return int'($urandom_range(1, 12));
    return 0;
  endfunction

  task automatic src_init(input int i, input int words, input int plen);
    words_left[i] = words;
    pkt_len[i]    = plen;
    pkt_left[i]   = reload(plen);
    seq[i]        = 0;
    fifo_seq[i]   = 0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) src_init(i, 0, 1);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (acc_vec[i]) begin
        seq[i]++;
        words_left[i]--;
        pkt_left[i]--;
        if (pkt_left[i] <= 0) pkt_left[i] = reload(pkt_len[i]);
      end
      req_valid[i] = (words_left[i] > 0) && (int'($urandom_range(0, 99)) < vld_pct);
      req_last[i]  = (pkt_len[i] != 0) && (pkt_left[i] == 1);
      req_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
    end
    wfull   = (int'($urandom_range(0, 99)) < wfull_pct);
    acc_vec = '0;
  endtask

  // Rule model: idle -> grant first valid requester in rotation from ptr; granted -> one word per
  // non-full valid cycle; burst ends on last or the MAXBURST-th word, ptr moves past the owner.
  task automatic model_check();
    logic ew;
    logic [NREQ-1:0] er;
    int id;
    s_busy = busy; s_winc = winc; s_ready = req_ready;
    acc_vec = req_ready;
    if (!wrst_n) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      chk("rst_busy", busy, 0);
      chk("rst_winc", winc, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_gnt", gnt_id, 0);
      return;
    end
    ew = (m_busy != 0) && req_valid[m_owner] && !wfull;
    er = ew ? (NREQ'(1) << m_owner) : '0;
    chk("busy", busy, m_busy);
    chk("winc", winc, ew);
    chk("req_ready", req_ready, er);
    if (m_busy != 0) chk("gnt_id", gnt_id, m_owner);
    if (ew) chk("wdata", wdata, req_data[m_owner*DW +: DW]);
    if (winc) begin
      chk("fifo_order", wdata, {2'(m_owner), 6'(fifo_seq[m_owner])});
      fifo_seq[m_owner]++;
      owner_log.push_back(m_owner);
    end
    if (m_busy == 0) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        id = (m_ptr + k) % NREQ;
        if (req_valid[id]) begin
          m_busy = 1; m_owner = id; m_cnt = 0;
        end
      end
    end else if (ew) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MAXBURST) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic step();
    @(negedge wclk);
    model_check();
    @(posedge wclk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    acc_vec = '0;
    step();
    step();
    wrst_n = 1'b1;
    owner_log.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_id[$];
    int run_len[$];
    int exp_id[5]  = '{0, 1, 0, 1, 0};
    int exp_len[5] = '{8, 1, 8, 1, 4};
    int stalls;

    wrst_n = 1'b0; req_valid = '0; req_last = '0; wfull = 1'b0; acc_vec = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    clear_sources();

    //   rst  vld      lst      full busy gnt winc rdy
    add(0, 4'b0000, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0010, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0010, 4'b0000, 0,   1, 1, 1, 4'b0010);
    add(1, 4'b0010, 4'b0000, 0,   1, 1, 1, 4'b0010);
    add(1, 4'b0010, 4'b0010, 0,   1, 1, 1, 4'b0010);
    add(1, 4'b0000, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0011, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0011, 4'b0001, 0,   1, 0, 1, 4'b0001);
    add(1, 4'b0000, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(0, 4'b0000, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b1101, 4'b1101, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b1101, 4'b1101, 0,   1, 0, 1, 4'b0001);
    add(1, 4'b1100, 4'b1100, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b1100, 4'b1100, 0,   1, 2, 1, 4'b0100);
    add(1, 4'b1000, 4'b1000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b1000, 4'b1000, 0,   1, 3, 1, 4'b1000);
    add(1, 4'b0000, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0100, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0100, 4'b0000, 1,   1, 2, 0, 4'b0000);
    add(1, 4'b0100, 4'b0100, 0,   1, 2, 1, 4'b0100);
    add(1, 4'b0000, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0001, 4'b0000, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0000, 4'b0000, 0,   1, 0, 0, 4'b0000);
    add(1, 4'b0010, 4'b0000, 0,   1, 0, 0, 4'b0000);
    add(1, 4'b0011, 4'b0001, 0,   1, 0, 1, 4'b0001);
    add(1, 4'b0010, 4'b0010, 0,   0, 0, 0, 4'b0000);
    add(1, 4'b0010, 4'b0010, 0,   1, 1, 1, 4'b0010);
    add(1, 4'b0000, 4'b0000, 0,   0, 0, 0, 4'b0000);

    for (int v = 0; v < tbl.size(); v++) begin
      @(posedge wclk);
      #1;
      wrst_n = tbl[v].rst_n; req_valid = tbl[v].vld; req_last = tbl[v].lst; wfull = tbl[v].full;
      @(negedge wclk);
      chk($sformatf("vec%0d_busy", v), busy, tbl[v].e_busy);
      chk($sformatf("vec%0d_winc", v), winc, tbl[v].e_winc);
      chk($sformatf("vec%0d_ready", v), req_ready, tbl[v].e_rdy);
      if (tbl[v].e_busy) chk($sformatf("vec%0d_gnt", v), gnt_id, tbl[v].e_gnt);
      if (tbl[v].e_winc) chk($sformatf("vec%0d_wdata", v), wdata, 8'hA0 + tbl[v].e_gnt);
    end
    @(posedge wclk);
    #1;

    // Long stream without last: bursts capped, requester 1 slotted in between.
    clear_sources(); do_reset();
    src_init(0, 20, 0); src_init(1, 2, 1); drive();
    for (int n = 0; n < 60 && words_left[0] > 0; n++) step();
    chk("r34_drained", words_left[0], 0);
    foreach (owner_log[k]) begin
      if (run_id.size() > 0 && run_id[run_id.size()-1] == owner_log[k])
        run_len[run_len.size()-1]++;
      else begin
        run_id.push_back(owner_log[k]);
        run_len.push_back(1);
      end
    end
    chk("r34_nruns", run_id.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < run_id.size()) begin
        chk($sformatf("r34_run%0d_id", k), run_id[k], exp_id[k]);
        chk($sformatf("r34_run%0d_len", k), run_len[k], exp_len[k]);
      end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    chk("r34_stat_words0", stat_words[15:0], 20);
    chk("r34_stat_stall", stat_stall, 0);
`endif

    // FIFO full for five cycles in the middle of a burst.
    clear_sources(); do_reset();
    src_init(3, 6, 6); drive();
    for (int n = 0; n < 20 && fifo_seq[3] < 2; n++) step();
    chk("r35_two_words", fifo_seq[3], 2);
    wfull = 1'b1; wfull_pct = 100;
    stalls = 0;
    for (int n = 0; n < 5; n++) begin
      if (n == 4) wfull_pct = 0;
      step();
      if (s_busy && !s_winc && s_ready == '0) stalls++;
    end
    chk("r35_stall_cycles", stalls, 5);
    for (int n = 0; n < 20 && (words_left[3] > 0 || busy); n++) step();
    chk("r35_words_in_fifo", fifo_seq[3], 6);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("r35_stat_stall", stat_stall, 5);
    chk("r35_stat_words3", stat_words[63:48], 6);
`endif

    // Asynchronous reset in the middle of a burst.
    clear_sources(); do_reset();
    src_init(1, 5, 5); drive();
    for (int n = 0; n < 20 && fifo_seq[1] < 2; n++) step();
    chk("r36_two_words", fifo_seq[1], 2);
    chk("r36_pre_busy", busy, 1);
    wrst_n = 1'b0;
    #1;
    chk("r36_rst_busy", busy, 0);
    chk("r36_rst_winc", winc, 0);
    chk("r36_rst_ready", req_ready, 0);
    chk("r36_rst_gnt", gnt_id, 0);
    step();
    clear_sources(); src_init(3, 1, 1); src_init(0, 1, 1);
    wrst_n = 1'b1; drive();
    step();
    chk("r36_busy_after", busy, 1);
    chk("r36_first_gnt", gnt_id, 0);
    repeat (6) step();
    chk("r36_req3_served", fifo_seq[3], 1);

    // Random traffic against the rule model.
    clear_sources(); do_reset();
    for (int i = 0; i < NREQ; i++) src_init(i, 150, -1);
    vld_pct = 75; wfull_pct = 20; drive();
    repeat (1500) step();
    for (int i = 0; i < NREQ; i++) chk($sformatf("rand_count%0d", i), fifo_seq[i], seq[i]);
    vld_pct = 100; wfull_pct = 0;

`ifdef FIFO_WR_ARB_STATS_EN
    // Word counter saturation.
    clear_sources(); do_reset();
    src_init(2, 66000, 0); drive();
    for (int n = 0; n < 80000 && words_left[2] > 0; n++) step();
    chk("sat_drained", words_left[2], 0);
    chk("sat_stat_words2", stat_words[47:32], 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
